iob_uart_host_bridge: RTL and testbench

IOB_UART_HOST_BRIDGE -- requirements
Module: iob_uart_host_bridge

---
 rtl/iob_uart_host_bridge_pkg.sv | 27 ++
 rtl/iob_uart_bridge_fifo.sv | 60 ++++++
 rtl/iob_uart_host_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_iob_uart_host_bridge.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_uart_host_bridge_pkg.sv
// Shared register map defaults and FSM state encoding for the UART host bridge.
package iob_uart_host_bridge_pkg;

    localparam int DEF_DIV_ADDR     = 1;
    localparam int DEF_TXDATA_ADDR  = 2;
    localparam int DEF_TXEN_ADDR    = 3;
    localparam int DEF_TXREADY_ADDR = 4;
    localparam int DEF_RXDATA_ADDR  = 5;
    localparam int DEF_RXEN_ADDR    = 6;
    localparam int DEF_RXREADY_ADDR = 7;

    localparam logic [3:0] WSTRB_READ = 4'h0;
    localparam logic [3:0] WSTRB_WORD = 4'hF;
    localparam logic [3:0] WSTRB_BYTE = 4'h1;

    typedef enum logic [2:0] {
        INIT_DIV,
        INIT_TXEN,
        INIT_RXEN,
        IDLE,
        POLL_RX,
        READ_RX,
        POLL_TX,
        WRITE_TX
    } state_t;

endpackage

// File: rtl/iob_uart_bridge_fifo.sv
// Byte FIFO with first-word fall-through read port and synchronous reset.
module iob_uart_bridge_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == C_FULL);
    assign o_rdata = r_mem[r_rptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_uart_host_bridge.sv
// Bridges host byte streams to a polled UART register bus: initialises the
// UART, then alternates between draining RX and feeding TX through two FIFOs.
module iob_uart_host_bridge
    import iob_uart_host_bridge_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 3,
    parameter int FIFO_DEPTH   = 16,
    parameter int TIMEOUT      = 1024,
    parameter int DIV_ADDR     = DEF_DIV_ADDR,
    parameter int TXDATA_ADDR  = DEF_TXDATA_ADDR,
    parameter int TXEN_ADDR    = DEF_TXEN_ADDR,
    parameter int TXREADY_ADDR = DEF_TXREADY_ADDR,
    parameter int RXDATA_ADDR  = DEF_RXDATA_ADDR,
    parameter int RXEN_ADDR    = DEF_RXEN_ADDR,
    parameter int RXREADY_ADDR = DEF_RXREADY_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] div,
    output logic              uart_valid,
    output logic [ADDR_W-1:0] uart_addr,
    output logic [DATA_W-1:0] uart_wdata,
    output logic [3:0]        uart_wstrb,
    input  logic [DATA_W-1:0] uart_rdata,
    input  logic              uart_ready,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              init_done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [TW-1:0]     r_wait;
    logic              r_init_done;
    logic              r_err;

    logic              w_done;
    logic              w_timeout;
    logic              w_flag;
    logic              w_req;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic [3:0]        w_req_wstrb;
    logic              w_rx_push;
    logic              w_tx_pop;
    logic              w_tx_push;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [7:0]        w_tx_head;
    logic [7:0]        w_rx_head;
    logic              w_unused_rdata;

    assign w_done         = r_valid & uart_ready;
    assign w_timeout      = r_valid & ~uart_ready & (r_wait == TW'(TIMEOUT - 1));
    assign w_flag         = uart_rdata[0];
    assign w_unused_rdata = ^uart_rdata;
    assign w_tx_push      = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT_DIV;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Init states simply hold on timeout, which reissues the same write.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INIT_DIV:  if (w_done) w_next_state = INIT_TXEN;
            INIT_TXEN: if (w_done) w_next_state = INIT_RXEN;
            INIT_RXEN: if (w_done) w_next_state = IDLE;
            IDLE: begin
                if (!w_rx_full) begin
                    w_next_state = POLL_RX;
                end else if (!w_tx_empty) begin
                    w_next_state = POLL_TX;
                end
            end
            POLL_RX: begin
                if (w_done) begin
                    w_next_state = w_flag ? READ_RX : (w_tx_empty ? IDLE : POLL_TX);
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            READ_RX: begin
                if (w_done) begin
                    w_next_state = w_tx_empty ? IDLE : POLL_TX;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            POLL_TX: begin
                if (w_done) begin
                    w_next_state = w_flag ? WRITE_TX : IDLE;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            WRITE_TX:  if (w_done || w_timeout) w_next_state = IDLE;
            default:   w_next_state = INIT_DIV;
        endcase
    end

    always_comb begin
        w_req       = 1'b1;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_wstrb = WSTRB_READ;
        w_rx_push   = 1'b0;
        w_tx_pop    = 1'b0;
        case (r_state)
            INIT_DIV: begin
                w_req_addr  = ADDR_W'(DIV_ADDR);
                w_req_wdata = div;
                w_req_wstrb = WSTRB_WORD;
            end
            INIT_TXEN: begin
                w_req_addr  = ADDR_W'(TXEN_ADDR);
                w_req_wdata = DATA_W'(1);
                w_req_wstrb = WSTRB_WORD;
            end
            INIT_RXEN: begin
                w_req_addr  = ADDR_W'(RXEN_ADDR);
                w_req_wdata = DATA_W'(1);
                w_req_wstrb = WSTRB_WORD;
            end
            IDLE:    w_req = 1'b0;
            POLL_RX: w_req_addr = ADDR_W'(RXREADY_ADDR);
            READ_RX: begin
                w_req_addr = ADDR_W'(RXDATA_ADDR);
                w_rx_push  = w_done;
            end
            POLL_TX: w_req_addr = ADDR_W'(TXREADY_ADDR);
            WRITE_TX: begin
                w_req_addr  = ADDR_W'(TXDATA_ADDR);
                w_req_wdata = DATA_W'(w_tx_head);
                w_req_wstrb = WSTRB_BYTE;
                w_tx_pop    = w_done;
            end
            default: w_req = 1'b0;
        endcase
    end

    // The request is latched on issue and held until completion or timeout; the
    // new state's first cycle always has uart_valid low, giving the drop cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_wait  <= '0;
        end else if (r_valid) begin
            if (w_done || w_timeout) begin
                r_valid <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
                r_wstrb <= '0;
            end else begin
                r_wait <= r_wait + 1'b1;
            end
        end else if (w_req) begin
            r_valid <= 1'b1;
            r_addr  <= w_req_addr;
            r_wdata <= w_req_wdata;
            r_wstrb <= w_req_wstrb;
            r_wait  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == INIT_RXEN && w_done) begin
                r_init_done <= 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    iob_uart_bridge_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_push),
        .i_wdata (tx_data),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full)
    );

    iob_uart_bridge_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_wdata (uart_rdata[7:0]),
        .i_pop   (rx_ready),
        .o_rdata (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full)
    );

    assign uart_valid = r_valid;
    assign uart_addr  = r_addr;
    assign uart_wdata = r_wdata;
    assign uart_wstrb = r_wstrb;
    assign init_done  = r_init_done;
    assign err        = r_err;
    assign tx_ready   = r_init_done & ~w_tx_full;
    assign rx_valid   = ~w_rx_empty;
    assign rx_data    = w_rx_head;

endmodule

// File: tb/tb_iob_uart_host_bridge.sv
// Self-checking bench: behavioural UART register model plus queue-based
// expectations for init writes, RX/TX streams, back-pressure and timeout.
module tb_iob_uart_host_bridge;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] div = '0;
    logic          uart_valid;
    logic [AW-1:0] uart_addr;
    logic [DW-1:0] uart_wdata;
    logic [3:0]    uart_wstrb;
    logic [DW-1:0] uart_rdata;
    logic          uart_ready;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          init_done;
    logic          err;

    int checks = 0;
    int errors = 0;

    // UART model controls and observations
    bit         respond = 1'b1;
    int         lat = 1;
    int         txr_mode = 0;
    int         tx_block = 0;
    int         n_rxrdy = 0;
    int         n_txrdy = 0;
    logic [7:0] rxq[$];
    logic [AW-1:0] wlog_a[$];
    logic [DW-1:0] wlog_d[$];
    logic [3:0]    wlog_s[$];

    always #5 clk = ~clk;

    iob_uart_host_bridge #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .div        (div),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .init_done  (init_done),
        .err        (err)
    );

    // Register-level UART: answers after `lat` waiting cycles, logs writes,
    // and checks that requests hold steady and valid drops after completion.
    initial begin : uart_model
        bit            r_was;
        bit            prev_v;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic [3:0]    ps;
        int            wait_n;
        uart_ready = 1'b0;
        uart_rdata = '0;
        prev_v = 1'b0;
        wait_n = 0;
        pa = '0; pd = '0; ps = '0;
        forever begin
            @(negedge clk);
            r_was = uart_ready;
            uart_ready = 1'b0;
            uart_rdata = '0;
            if (reset) begin
                prev_v = 1'b0;
                wait_n = 0;
            end else begin
                if (r_was) begin
                    checks++;
                    if (uart_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL bus_drop: uart_valid=%b required 0", uart_valid);
                    end
                end else if (prev_v && uart_valid) begin
                    checks++;
                    if (uart_addr !== pa || uart_wdata !== pd || uart_wstrb !== ps) begin
                        errors++;
                        $display("FAIL bus_stable: addr/wdata/wstrb=%0h/%0h/%0h required %0h/%0h/%0h",
                                 uart_addr, uart_wdata, uart_wstrb, pa, pd, ps);
                    end
                end
                if (uart_valid === 1'b1 && !r_was) begin
                    wait_n++;
                    if (respond && wait_n > lat) begin
                        wait_n = 0;
                        uart_ready = 1'b1;
                        uart_rdata = $urandom;
                        if (uart_wstrb != 4'h0) begin
                            wlog_a.push_back(uart_addr);
                            wlog_d.push_back(uart_wdata);
                            wlog_s.push_back(uart_wstrb);
                        end else if (uart_addr == 3'd7) begin
                            n_rxrdy++;
                            uart_rdata[0] = (rxq.size() > 0);
                        end else if (uart_addr == 3'd5) begin
                            uart_rdata[7:0] = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                        end else if (uart_addr == 3'd4) begin
                            n_txrdy++;
                            uart_rdata[0] = (txr_mode == 0) ? (n_txrdy > tx_block) : 1'($urandom_range(0, 1));
                        end
                    end
                end else begin
                    wait_n = 0;
                end
                prev_v = uart_valid;
                pa = uart_addr;
                pd = uart_wdata;
                ps = uart_wstrb;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        ok = (n < 500);
    endtask

    task automatic clear_log();
        wlog_a.delete();
        wlog_d.delete();
        wlog_s.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        div   = 32'd50;
        repeat (3) @(negedge clk);
        checks++; if (uart_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", uart_valid); end
        checks++; if (uart_wstrb !== 4'h0) begin errors++; $display("FAIL rst_wstrb: got %0h required 0", uart_wstrb); end
        checks++; if (uart_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0h required 0", uart_addr); end
        checks++; if (uart_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %0h required 0", uart_wdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b required 0", init_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_tx_ready: got %b required 0", tx_ready); end
    endtask

    // Releases reset (or continues from it) and checks the three init writes.
    task automatic test_init(input string tag);
        int ea[3] = '{1, 3, 6};
        int ed[3] = '{50, 1, 1};
        int n = 0;
        clear_log();
        reset = 1'b0;
        while (init_done !== 1'b1 && n < 300) begin
            checks++;
            if (tx_ready !== 1'b0) begin errors++; $display("FAIL %s_tx_ready_pre_init: got %b required 0", tag, tx_ready); end
            @(negedge clk);
            n++;
        end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL %s_init_done: got %b required 1", tag, init_done); end
        checks++;
        if (wlog_a.size() != 3) begin
            errors++; $display("FAIL %s_write_count: got %0d required 3", tag, wlog_a.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (int'(wlog_a[i]) != ea[i] || int'(wlog_d[i]) != ed[i] || wlog_s[i] !== 4'hF) begin
                    errors++;
                    $display("FAIL %s_write%0d: got (%0d,%0d,%0h) required (%0d,%0d,f)",
                             tag, i, wlog_a[i], wlog_d[i], wlog_s[i], ea[i], ed[i]);
                end
            end
        end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s_tx_ready_post_init: got %b required 1", tag, tx_ready); end
    endtask

    task automatic test_rx_sequence();
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        int n = 0;
        exp_q = '{8'h41, 8'h42, 8'h43};
        foreach (exp_q[i]) rxq.push_back(exp_q[i]);
        rx_ready = 1'b1;
        while (got.size() < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (rx_valid === 1'b1) got.push_back(rx_data);
        end
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL rx_seq_count: got %0d required 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rx_seq_byte%0d: got %0h required %0h", i, got[i], exp_q[i]); end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rx_seq_err: got %b required 0", err); end
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_rx_full();
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        int n = 0;
        int snap;
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            exp_q.push_back(8'($urandom));
            rxq.push_back(exp_q[i]);
        end
        while (rxq.size() > 1 && n < 500) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        snap = n_rxrdy;
        repeat (100) @(negedge clk);
        checks++; if (rxq.size() != 1) begin errors++; $display("FAIL rx_full_captured: left %0d required 1", rxq.size()); end
        checks++; if (n_rxrdy != snap) begin errors++; $display("FAIL rx_full_no_poll: polls %0d required %0d", n_rxrdy, snap); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_full_valid: got %b required 1", rx_valid); end
        rx_ready = 1'b1;
        got.push_back(rx_data);
        @(negedge clk);
        rx_ready = 1'b0;
        n = 0;
        while (rxq.size() > 0 && n < 500) begin @(negedge clk); n++; end
        checks++; if (rxq.size() != 0) begin errors++; $display("FAIL rx_full_fifth: left %0d required 0", rxq.size()); end
        n = 0;
        while (got.size() < DEPTH + 1 && n < 200) begin
            @(negedge clk);
            n++;
            rx_ready = 1'b1;
            if (rx_valid === 1'b1) got.push_back(rx_data);
        end
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (got.size() != DEPTH + 1) begin
            errors++; $display("FAIL rx_full_drain_count: got %0d required %0d", got.size(), DEPTH + 1);
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rx_full_byte%0d: got %0h required %0h", i, got[i], exp_q[i]); end
            end
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_full_empty: rx_valid %b required 0", rx_valid); end
    endtask

    task automatic test_tx_backpressure();
        bit ok;
        int n = 0;
        int snap;
        clear_log();
        txr_mode = 0;
        tx_block = 20;
        n_txrdy  = 0;
        send_byte(8'h55, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_accept: tx_ready stayed 0 required 1"); end
        while (wlog_a.size() == 0 && n < 3000) begin @(negedge clk); n++; end
        repeat (50) @(negedge clk);
        checks++;
        if (wlog_a.size() != 1) begin
            errors++; $display("FAIL tx_write_count: got %0d required 1", wlog_a.size());
        end else begin
            checks++;
            if (wlog_a[0] !== 3'd2 || wlog_d[0][7:0] !== 8'h55 || wlog_s[0] !== 4'h1) begin
                errors++;
                $display("FAIL tx_write: got (%0d,%0h,%0h) required (2,55,1)", wlog_a[0], wlog_d[0][7:0], wlog_s[0]);
            end
        end
        checks++; if (n_txrdy != tx_block + 1) begin errors++; $display("FAIL tx_polls: got %0d required %0d", n_txrdy, tx_block + 1); end
        snap = n_txrdy;
        repeat (100) @(negedge clk);
        checks++; if (n_txrdy != snap) begin errors++; $display("FAIL tx_fifo_empty: polls %0d required %0d", n_txrdy, snap); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after: got %b required 1", tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tx[$];
        logic [7:0] exp_rx[$];
        logic [7:0] got[$];
        int n = 0;
        bit all_ok = 1'b1;
        clear_log();
        txr_mode = 1;
        for (int i = 0; i < 6; i++) begin
            exp_rx.push_back(8'($urandom));
            rxq.push_back(exp_rx[i]);
        end
        fork
            begin
                bit ok;
                logic [7:0] b;
                for (int i = 0; i < 10; i++) begin
                    b = 8'($urandom);
                    exp_tx.push_back(b);
                    send_byte(b, ok);
                    all_ok &= ok;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                int m = 0;
                while (got.size() < 6 && m < 3000) begin
                    @(negedge clk);
                    m++;
                    rx_ready = 1'($urandom_range(0, 1));
                    if (rx_valid === 1'b1 && rx_ready) got.push_back(rx_data);
                end
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        checks++; if (!all_ok) begin errors++; $display("FAIL b2b_tx_accept: a push timed out"); end
        while (wlog_a.size() < 10 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (wlog_a.size() != 10) begin
            errors++; $display("FAIL b2b_tx_count: got %0d required 10", wlog_a.size());
        end else begin
            foreach (exp_tx[i]) begin
                checks++;
                if (wlog_a[i] !== 3'd2 || wlog_d[i][7:0] !== exp_tx[i] || wlog_s[i] !== 4'h1) begin
                    errors++;
                    $display("FAIL b2b_tx%0d: got (%0d,%0h,%0h) required (2,%0h,1)", i, wlog_a[i], wlog_d[i][7:0], wlog_s[i], exp_tx[i]);
                end
            end
        end
        checks++;
        if (got.size() != 6) begin
            errors++; $display("FAIL b2b_rx_count: got %0d required 6", got.size());
        end else begin
            foreach (exp_rx[i]) begin
                checks++;
                if (got[i] !== exp_rx[i]) begin errors++; $display("FAIL b2b_rx%0d: got %0h required %0h", i, got[i], exp_rx[i]); end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b required 0", err); end
    endtask

    task automatic test_timeout();
        int n = 0;
        int hi = 0;
        respond = 1'b0;
        while (uart_valid !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (uart_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (uart_valid !== 1'b1) begin errors++; $display("FAIL tmo_issue: uart_valid %b required 1", uart_valid); end
        while (uart_valid === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
        checks++; if (hi != TMO) begin errors++; $display("FAIL tmo_cycles: valid high %0d cycles required %0d", hi, TMO); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL tmo_no_push: rx_valid %b required 0", rx_valid); end
        n = 0;
        while (uart_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b required 1", err); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_rst_err: got %b required 0", err); end
        checks++; if (uart_valid !== 1'b0) begin errors++; $display("FAIL tmo_rst_valid: got %b required 0", uart_valid); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL tmo_rst_init_done: got %b required 0", init_done); end
        respond = 1'b1;
        test_init("reinit");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init("init");
        test_rx_sequence();
        test_rx_full();
        test_tx_backpressure();
        test_back_to_back();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
